// File: rtl/vga_timing_pkg.sv
// Shared types and timing sets for the raster timing generator.
// Counter widths, the per-axis phase enum and the XGA/VGA parameter sets live here.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  localparam int CNT_W   = 11;
  localparam int CNT_MAX = 2047;
  localparam int FRAME_W = 10;

  // 1024x768@60, 65 MHz pixel rate
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;

  // 640x480@60
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Every phase needs at least one count, and the total must fit the counter.
  function automatic bit timing_fits(int a, int fp, int s, int bp);
    return (a > 0) && (fp > 0) && (s > 0) && (bp > 0) && ((a + fp + s + bp) <= CNT_MAX);
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrapping counter plus ACTIVE->FRONT->SYNC->BACK phase FSM.
// The phase register always describes the current count value.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = XGA_H_ACTIVE,
  parameter int FP_LEN     = XGA_H_FP,
  parameter int SYNC_LEN   = XGA_H_SYNC,
  parameter int BP_LEN     = XGA_H_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output phase_t           phase,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(ACTIVE_LEN + FP_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_TOTAL  = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN - 1);

  phase_t phase_next;

  assign wrap = (count == LAST_TOTAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (advance) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= ACTIVE;
    end else begin
      phase <= phase_next;
    end
  end

  // Leave a phase on the advance that consumes its last count.
  always_comb begin
    phase_next = phase;
    if (advance) begin
      case (phase)
        ACTIVE:  if (count == LAST_ACTIVE) phase_next = FRONT;
        FRONT:   if (count == LAST_FRONT)  phase_next = SYNC;
        SYNC:    if (count == LAST_SYNC)   phase_next = BACK;
        BACK:    if (wrap)                 phase_next = ACTIVE;
        default: phase_next = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/xga_timing_gen.sv
// Raster timing source: cascaded horizontal/vertical axes with one registered,
// mutually aligned output set per pixel-clock-enable.
module xga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = XGA_H_ACTIVE,
  parameter int H_FP       = XGA_H_FP,
  parameter int H_SYNC     = XGA_H_SYNC,
  parameter int H_BP       = XGA_H_BP,
  parameter int V_ACTIVE   = XGA_V_ACTIVE,
  parameter int V_FP       = XGA_V_FP,
  parameter int V_SYNC     = XGA_V_SYNC,
  parameter int V_BP       = XGA_V_BP,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               video_active,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  if (!timing_fits(H_ACTIVE, H_FP, H_SYNC, H_BP)) begin : g_h_bad
    $error("horizontal timing parameters do not fit the 11-bit counter");
  end
  if (!timing_fits(V_ACTIVE, V_FP, V_SYNC, V_BP)) begin : g_v_bad
    $error("vertical timing parameters do not fit the 11-bit counter");
  end

  logic [CNT_W-1:0]   h_count;
  logic [CNT_W-1:0]   v_count;
  phase_t             h_phase;
  phase_t             v_phase;
  logic               h_wrap;
  logic               v_wrap;
  logic               v_advance;
  logic [FRAME_W-1:0] frame_q;

  assign v_advance = en & h_wrap;

  timing_axis #(
    .ACTIVE_LEN(H_ACTIVE),
    .FP_LEN    (H_FP),
    .SYNC_LEN  (H_SYNC),
    .BP_LEN    (H_BP)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .advance(en),
    .count  (h_count),
    .phase  (h_phase),
    .wrap   (h_wrap)
  );

  timing_axis #(
    .ACTIVE_LEN(V_ACTIVE),
    .FP_LEN    (V_FP),
    .SYNC_LEN  (V_SYNC),
    .BP_LEN    (V_BP)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .advance(v_advance),
    .count  (v_count),
    .phase  (v_phase),
    .wrap   (v_wrap)
  );

  // Frame count travels with the counters, so the output copy flips with pixel (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else if (en && h_wrap && v_wrap) begin
      frame_q <= frame_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x        <= '0;
      pix_y        <= '0;
      video_active <= 1'b0;
      hsync        <= ~H_SYNC_POL;
      vsync        <= ~V_SYNC_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      frame_cnt    <= '0;
    end else if (en) begin
      pix_x        <= h_count;
      pix_y        <= v_count;
      video_active <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
      hsync        <= (h_phase == SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync        <= (v_phase == SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
      line_start   <= (h_count == '0);
      frame_start  <= (h_count == '0) && (v_count == '0);
      frame_cnt    <= frame_q;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xga_timing_gen.sv
// Bench for xga_timing_gen: XGA, VGA and a tiny-raster instance checked every cycle
// against an arithmetic pixel-index model, plus directed literal expectations.
module tb_xga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        va;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [9:0]  fc;
  } obs_t;

  typedef struct {
    int ha, hfp, hs, hbp;
    int va, vfp, vs, vbp;
    bit hp, vp;
  } tim_t;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_xg = 1'b1, en_xg = 1'b0;
  logic rst_vg = 1'b1, en_vg = 1'b0;
  logic rst_sm = 1'b1, en_sm = 1'b0;

  logic [10:0] xg_px, xg_py, vg_px, vg_py, sm_px, sm_py;
  logic xg_va, xg_hs, xg_vs, xg_ls, xg_fs;
  logic vg_va, vg_hs, vg_vs, vg_ls, vg_fs;
  logic sm_va, sm_hs, sm_vs, sm_ls, sm_fs;
  logic [9:0] xg_fc, vg_fc, sm_fc;

  xga_timing_gen u_xga (
    .clk(clk), .rst(rst_xg), .en(en_xg), .pix_x(xg_px), .pix_y(xg_py),
    .video_active(xg_va), .hsync(xg_hs), .vsync(xg_vs), .line_start(xg_ls),
    .frame_start(xg_fs), .frame_cnt(xg_fc)
  );

  xga_timing_gen #(
    .H_ACTIVE(VGA_H_ACTIVE), .H_FP(VGA_H_FP), .H_SYNC(VGA_H_SYNC), .H_BP(VGA_H_BP),
    .V_ACTIVE(VGA_V_ACTIVE), .V_FP(VGA_V_FP), .V_SYNC(VGA_V_SYNC), .V_BP(VGA_V_BP)
  ) u_vga (
    .clk(clk), .rst(rst_vg), .en(en_vg), .pix_x(vg_px), .pix_y(vg_py),
    .video_active(vg_va), .hsync(vg_hs), .vsync(vg_vs), .line_start(vg_ls),
    .frame_start(vg_fs), .frame_cnt(vg_fc)
  );

  // 8x6 raster (48-clock frame), active-high syncs
  xga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .rst(rst_sm), .en(en_sm), .pix_x(sm_px), .pix_y(sm_py),
    .video_active(sm_va), .hsync(sm_hs), .vsync(sm_vs), .line_start(sm_ls),
    .frame_start(sm_fs), .frame_cnt(sm_fc)
  );

  tim_t t_xg, t_vg, t_sm;
  initial begin
    t_xg = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};
    t_vg = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    t_sm = '{4, 1, 1, 2, 3, 1, 1, 1, 1'b1, 1'b1};
  end

  // n = en edges since reset; the output shows pixel index n-1 of the raster.
  function automatic obs_t model(tim_t t, longint n, bit pulse);
    obs_t o;
    longint p, ht, vt, x, y;
    ht = t.ha + t.hfp + t.hs + t.hbp;
    vt = t.va + t.vfp + t.vs + t.vbp;
    if (n == 0) begin
      o.x = '0; o.y = '0; o.va = 1'b0; o.hs = ~t.hp; o.vs = ~t.vp;
      o.ls = 1'b0; o.fs = 1'b0; o.fc = '0;
      return o;
    end
    p = n - 1;
    x = p % ht;
    y = (p / ht) % vt;
    o.x  = 11'(x);
    o.y  = 11'(y);
    o.va = (x < t.ha) && (y < t.va);
    o.hs = (x >= t.ha + t.hfp && x < t.ha + t.hfp + t.hs) ? t.hp : ~t.hp;
    o.vs = (y >= t.va + t.vfp && y < t.va + t.vfp + t.vs) ? t.vp : ~t.vp;
    o.ls = pulse && (x == 0);
    o.fs = pulse && (x == 0) && (y == 0);
    o.fc = 10'((p / (ht * vt)) % 1024);
    return o;
  endfunction

  longint n_xg = 0, n_vg = 0, n_sm = 0;
  bit p_xg = 0, p_vg = 0, p_sm = 0;

  always @(posedge clk or posedge rst_xg)
    if (rst_xg) begin n_xg <= 0; p_xg <= 0; end
    else begin if (en_xg) n_xg <= n_xg + 1; p_xg <= en_xg; end
  always @(posedge clk or posedge rst_vg)
    if (rst_vg) begin n_vg <= 0; p_vg <= 0; end
    else begin if (en_vg) n_vg <= n_vg + 1; p_vg <= en_vg; end
  always @(posedge clk or posedge rst_sm)
    if (rst_sm) begin n_sm <= 0; p_sm <= 0; end
    else begin if (en_sm) n_sm <= n_sm + 1; p_sm <= en_sm; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual x=%0d y=%0d va=%b hs=%b vs=%b ls=%b fs=%b fc=%0d required x=%0d y=%0d va=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
               name, act.x, act.y, act.va, act.hs, act.vs, act.ls, act.fs, act.fc,
               exp.x, exp.y, exp.va, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk_obs("model_xga", {xg_px, xg_py, xg_va, xg_hs, xg_vs, xg_ls, xg_fs, xg_fc}, model(t_xg, n_xg, p_xg));
      chk_obs("model_vga", {vg_px, vg_py, vg_va, vg_hs, vg_vs, vg_ls, vg_fs, vg_fc}, model(t_vg, n_vg, p_vg));
      chk_obs("model_small", {sm_px, sm_py, sm_va, sm_hs, sm_vs, sm_ls, sm_fs, sm_fc}, model(t_sm, n_sm, p_sm));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t m;
    int ls_e[$];
    int fs_e[$];
    int hs_first, hs_last, hs_cnt, w, period, bad_ls, bad_hold, vs_cnt, vs_x, vs_y;
    logic [10:0] prev_x;

    // Literal pins on the model itself.
    m = model(t_xg, 1049, 1'b1);  chk("pin_model_xga_hsync_1048", m.hs, 1'b0);
    m = model(t_xg, 1048, 1'b1);  chk("pin_model_xga_hsync_1047", m.hs, 1'b1);
    m = model(t_xg, 1345, 1'b1);  chk("pin_model_xga_line1_y", m.y, 1);
    m = model(t_vg, 657, 1'b1);   chk("pin_model_vga_hsync_656", m.hs, 1'b0);
    m = model(t_sm, 49, 1'b1);    chk("pin_model_small_fc", m.fc, 1);

    repeat (3) tick();
    started = 1;
    chk("reset_xga_x", xg_px, 0);
    chk("reset_xga_hsync", xg_hs, 1'b1);
    chk("reset_xga_vsync", xg_vs, 1'b1);
    chk("reset_xga_va", xg_va, 1'b0);
    chk("reset_small_hsync", sm_hs, 1'b0);
    rst_xg = 1'b0; rst_vg = 1'b0; rst_sm = 1'b0;
    tick();

    // XGA first line and line timing
    en_xg = 1'b1;
    hs_first = -1; hs_last = -1; hs_cnt = 0;
    for (int e = 1; e <= 1345; e++) begin
      tick();
      if (e == 1) begin
        chk("xga_first_x", xg_px, 0);
        chk("xga_first_y", xg_py, 0);
        chk("xga_first_va", xg_va, 1'b1);
        chk("xga_first_fs", xg_fs, 1'b1);
        chk("xga_first_ls", xg_ls, 1'b1);
      end
      if (e == 1024) begin
        chk("xga_edge1024_x", xg_px, 1023);
        chk("xga_edge1024_va", xg_va, 1'b1);
      end
      if (e == 1025) chk("xga_edge1025_va", xg_va, 1'b0);
      if (e <= 1344 && xg_hs == 1'b0) begin
        if (hs_first < 0) hs_first = int'(xg_px);
        hs_last = int'(xg_px);
        hs_cnt++;
      end
      if (xg_ls) ls_e.push_back(e);
      if (e == 1345) chk("xga_line1_y", xg_py, 1);
    end
    chk("xga_hsync_first_x", hs_first, 1048);
    chk("xga_hsync_last_x", hs_last, 1183);
    chk("xga_hsync_len", hs_cnt, 136);
    period = (ls_e.size() >= 2) ? ls_e[1] - ls_e[0] : -1;
    chk("xga_line_period", period, 1344);

    // XGA async reset mid-line
    w = 0;
    while (xg_px != 11'd500 && w < 2000) begin tick(); w++; end
    chk("xga_wait_x500", w < 2000, 1'b1);
    chk("xga_pre_reset_y", xg_py, 1);
    #2 rst_xg = 1'b1;
    #1;
    chk("xga_async_rst_x", xg_px, 0);
    chk("xga_async_rst_y", xg_py, 0);
    chk("xga_async_rst_hsync", xg_hs, 1'b1);
    chk("xga_async_rst_vsync", xg_vs, 1'b1);
    chk("xga_async_rst_va", xg_va, 1'b0);
    tick();
    rst_xg = 1'b0;
    tick();
    chk("xga_restart_x", xg_px, 0);
    chk("xga_restart_fs", xg_fs, 1'b1);
    en_xg = 1'b0;

    // VGA parameter set
    en_vg = 1'b1;
    hs_first = -1; hs_last = -1; hs_cnt = 0;
    ls_e.delete();
    for (int e = 1; e <= 801; e++) begin
      tick();
      if (e == 640) chk("vga_last_active_va", vg_va, 1'b1);
      if (e == 641) chk("vga_first_blank_va", vg_va, 1'b0);
      if (e <= 800 && vg_hs == 1'b0) begin
        if (hs_first < 0) hs_first = int'(vg_px);
        hs_last = int'(vg_px);
        hs_cnt++;
      end
      if (vg_ls) ls_e.push_back(e);
    end
    chk("vga_hsync_first_x", hs_first, 656);
    chk("vga_hsync_last_x", hs_last, 751);
    chk("vga_hsync_len", hs_cnt, 96);
    period = (ls_e.size() >= 2) ? ls_e[1] - ls_e[0] : -1;
    chk("vga_line_period", period, 800);
    en_vg = 1'b0;

    // Small raster: frame timing
    en_sm = 1'b1;
    vs_cnt = 0; vs_x = -1; vs_y = -1;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (sm_fs) fs_e.push_back(e);
      if (e == 48) chk("small_fc_before_wrap", sm_fc, 0);
      if (e == 49) chk("small_fc_after_wrap", sm_fc, 1);
      if (e <= 48 && sm_vs == 1'b1) begin
        if (vs_x < 0) begin vs_x = int'(sm_px); vs_y = int'(sm_py); end
        vs_cnt++;
      end
    end
    period = (fs_e.size() >= 2) ? fs_e[1] - fs_e[0] : -1;
    chk("small_frame_period", period, 48);
    chk("small_vsync_len", vs_cnt, 8);
    chk("small_vsync_first_x", vs_x, 0);
    chk("small_vsync_first_y", vs_y, 4);

    // en alternating: frame period doubles, pulses never on en=0 edges, levels hold
    fs_e.delete();
    bad_ls = 0; bad_hold = 0;
    for (int k = 0; k < 300; k++) begin
      en_sm = (k % 2 == 0);
      prev_x = sm_px;
      tick();
      if (!en_sm && (sm_ls || sm_fs)) bad_ls++;
      if (!en_sm && sm_px != prev_x) bad_hold++;
      if (sm_fs) fs_e.push_back(k);
    end
    chk("toggle_pulse_on_idle", bad_ls, 0);
    chk("toggle_hold_on_idle", bad_hold, 0);
    period = (fs_e.size() >= 2) ? fs_e[1] - fs_e[0] : -1;
    chk("toggle_frame_period", period, 96);

    // Small raster async reset mid-frame
    en_sm = 1'b1;
    w = 0;
    while (!(sm_px == 11'd5 && sm_py == 11'd2) && w < 200) begin tick(); w++; end
    chk("small_wait_5_2", w < 200, 1'b1);
    #2 rst_sm = 1'b1;
    #1;
    chk("small_async_rst_x", sm_px, 0);
    chk("small_async_rst_y", sm_py, 0);
    chk("small_async_rst_hsync", sm_hs, 1'b0);
    chk("small_async_rst_vsync", sm_vs, 1'b0);
    chk("small_async_rst_fc", sm_fc, 0);
    tick();
    rst_sm = 1'b0;

    // frame_cnt wraps after 1024 frames
    for (int e = 1; e <= 1024 * 48 + 1; e++) begin
      tick();
      if (e == 1) chk("wrap_start_fs", sm_fs, 1'b1);
      if (e == 512 * 48 + 1) chk("wrap_fc_512", sm_fc, 512);
      if (e == 1024 * 48) chk("wrap_fc_1023", sm_fc, 1023);
      if (e == 1024 * 48 + 1) begin
        chk("wrap_fc_0", sm_fc, 0);
        chk("wrap_fs", sm_fs, 1'b1);
      end
    end
    en_sm = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
